// File: rtl/fft_output_reorder_pkg.sv
// Shared FFT definitions: default datapath sizes, read FSM states and the
// bit-reversal helper used to turn SDF output order into natural order.
package fft_output_reorder_pkg;

   localparam int DEFAULT_WIDTH = 16;
   localparam int DEFAULT_N     = 16;

   // Widest index the bit-reversal helper supports (FFT sizes up to 64K points).
   localparam int BITREV_MAX    = 16;

   typedef enum logic {
      IDLE,
      READ
   } rd_state_t;

   // Reverses the low 'bits' bits of 'value'. The whole word is mirrored first
   // and then shifted down, so the loop bounds stay constant for synthesis.
   function automatic logic [BITREV_MAX-1:0] bitrev(input logic [BITREV_MAX-1:0] value,
                                                    input int bits);
      logic [BITREV_MAX-1:0] flipped;
      for (int i = 0; i < BITREV_MAX; i++) begin
         flipped[i] = value[BITREV_MAX-1-i];
      end
      return flipped >> (BITREV_MAX - bits);
   endfunction

endpackage

// File: rtl/fft_pingpong_bank.sv
// Two N-entry complex sample banks. One synchronous write port and one
// combinational read port, each selecting its own bank, so one frame can
// fill while the other drains. Contents have no reset.
module fft_pingpong_bank
   import fft_output_reorder_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH,
   parameter int N     = DEFAULT_N,
   localparam int LOG2N = $clog2(N)
) (
   input  logic                 clk,
   input  logic                 wr_en,
   input  logic                 wr_bank,
   input  logic [LOG2N-1:0]     wr_addr,
   input  logic [2*WIDTH-1:0]   wr_data,
   input  logic                 rd_bank,
   input  logic [LOG2N-1:0]     rd_addr,
   output logic [2*WIDTH-1:0]   rd_data
);

   logic [2*WIDTH-1:0] mem [2][N];

   // Store one packed {re, im} sample into the selected bank.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_bank][wr_addr] <= wr_data;
      end
   end

   assign rd_data = mem[rd_bank][rd_addr];

endmodule

// File: rtl/fft_output_reorder.sv
// Output reorder stage for the radix-2^2 SDF FFT. Samples arrive in
// bit-reversed order and are scattered into a ping-pong bank; a full bank is
// then read out sequentially, giving natural-order bins with an index tag and
// an end-of-frame flag. Back-to-back frames stream without gaps.
module fft_output_reorder
   import fft_output_reorder_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH,
   parameter int N     = DEFAULT_N,
   localparam int LOG2N = $clog2(N)
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    Enable,
   input  logic                    In_Valid,
   input  logic signed [WIDTH-1:0] In_Re,
   input  logic signed [WIDTH-1:0] In_Im,
   output logic                    Out_Valid,
   output logic signed [WIDTH-1:0] Out_Re,
   output logic signed [WIDTH-1:0] Out_Im,
   output logic [LOG2N-1:0]        Out_Index,
   output logic                    Out_Last
);

   localparam logic [LOG2N-1:0] LAST_IDX = LOG2N'(N - 1);

   rd_state_t          state;
   logic [LOG2N-1:0]   wr_cnt;
   logic [LOG2N-1:0]   wr_addr;
   logic               wr_bank;
   logic               wr_en;
   logic               wr_last;
   logic [1:0]         full;
   logic [1:0]         full_next;
   logic [LOG2N-1:0]   rd_cnt;
   logic [LOG2N-1:0]   rd_addr;
   logic               rd_bank;
   logic               rd_last;
   logic               sel_bank;
   logic               port_bank;
   logic               other_bank;
   logic               other_ready;
   logic [2*WIDTH-1:0] rd_data;

   assign wr_en   = Enable && In_Valid && !rst;
   assign wr_last = wr_en && (wr_cnt == LAST_IDX);
   assign wr_addr = LOG2N'(bitrev(BITREV_MAX'(wr_cnt), LOG2N));

   assign rd_last     = (state == READ) && (rd_cnt == LAST_IDX);
   assign sel_bank    = (full == 2'b11) ? ~wr_bank : full[1];
   assign port_bank   = (state == IDLE) ? sel_bank : rd_bank;
   assign rd_addr     = (state == IDLE) ? '0 : rd_cnt;
   assign other_bank  = ~rd_bank;
   assign other_ready = full[other_bank] || (wr_last && (wr_bank == other_bank));

   // Next full flags: a completed write marks its bank, and draining the last
   // bin frees the read bank; the read takes priority on a collision.
   always_comb begin
      full_next = full;
      if (wr_last) begin
         full_next[wr_bank] = 1'b1;
      end
      if (rd_last) begin
         full_next[rd_bank] = 1'b0;
      end
   end

   // Write side: advance the input counter and flip banks on each completed frame.
   always_ff @(posedge clk) begin
      if (rst || !Enable) begin
         wr_cnt  <= '0;
         wr_bank <= 1'b0;
         full    <= '0;
      end else begin
         full <= full_next;
         if (wr_en) begin
            wr_cnt <= wr_cnt + LOG2N'(1);
            if (wr_last) begin
               wr_bank <= ~wr_bank;
            end
         end
      end
   end

   // Read FSM: start on any full bank, emit N contiguous bins, then chain
   // straight into the other bank if it is ready or go back to idle.
   always_ff @(posedge clk) begin
      if (rst || !Enable) begin
         state     <= IDLE;
         rd_cnt    <= '0;
         rd_bank   <= 1'b0;
         Out_Valid <= 1'b0;
         Out_Re    <= '0;
         Out_Im    <= '0;
         Out_Index <= '0;
         Out_Last  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (|full) begin
                  state     <= READ;
                  rd_bank   <= sel_bank;
                  rd_cnt    <= LOG2N'(1);
                  Out_Valid <= 1'b1;
                  Out_Re    <= rd_data[2*WIDTH-1:WIDTH];
                  Out_Im    <= rd_data[WIDTH-1:0];
                  Out_Index <= '0;
                  Out_Last  <= 1'b0;
               end else begin
                  Out_Valid <= 1'b0;
                  Out_Last  <= 1'b0;
               end
            end
            READ: begin
               Out_Valid <= 1'b1;
               Out_Re    <= rd_data[2*WIDTH-1:WIDTH];
               Out_Im    <= rd_data[WIDTH-1:0];
               Out_Index <= rd_cnt;
               Out_Last  <= (rd_cnt == LAST_IDX);
               rd_cnt    <= rd_cnt + LOG2N'(1);
               if (rd_last) begin
                  if (other_ready) begin
                     rd_bank <= other_bank;
                  end else begin
                     state <= IDLE;
                  end
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   fft_pingpong_bank #(
      .WIDTH (WIDTH),
      .N     (N)
   ) u_bank (
      .clk     (clk),
      .wr_en   (wr_en),
      .wr_bank (wr_bank),
      .wr_addr (wr_addr),
      .wr_data ({In_Re, In_Im}),
      .rd_bank (port_bank),
      .rd_addr (rd_addr),
      .rd_data (rd_data)
   );

endmodule

// File: tb/tb_fft_output_reorder.sv
// Directed self-checking bench for fft_output_reorder (16-point, 16-bit).
module tb_fft_output_reorder;

   logic               clk = 1'b0;
   logic               rst;
   logic               enable;
   logic               in_valid;
   logic signed [15:0] in_re;
   logic signed [15:0] in_im;
   logic               out_valid;
   logic signed [15:0] out_re;
   logic signed [15:0] out_im;
   logic [3:0]         out_index;
   logic               out_last;

   int tests_run    = 0;
   int tests_failed = 0;

   // Natural bin n holds the sample that arrived n-th in bit-reversed order.
   int order [16] = '{0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15};

   always #5 clk = ~clk;

   fft_output_reorder #(
      .WIDTH (16),
      .N     (16)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .Enable    (enable),
      .In_Valid  (in_valid),
      .In_Re     (in_re),
      .In_Im     (in_im),
      .Out_Valid (out_valid),
      .Out_Re    (out_re),
      .Out_Im    (out_im),
      .Out_Index (out_index),
      .Out_Last  (out_last)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic valid, input int re, input int im);
      in_valid = valid;
      in_re    = 16'(re);
      in_im    = 16'(im);
      tick();
   endtask

   task automatic checkOutput(input string tag, input logic [15:0] observed,
                              input logic [15:0] expected);
      tests_run++;
      assert (observed === expected)
      else begin
         tests_failed++;
         $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
      end
   endtask

   task automatic checkBeat(input string tag, input logic valid, input int re,
                            input int im, input int idx, input logic last);
      checkOutput({tag, " valid"}, 16'(out_valid), 16'(valid));
      checkOutput({tag, " re"},    16'(out_re),    16'(re));
      checkOutput({tag, " im"},    16'(out_im),    16'(im));
      checkOutput({tag, " index"}, 16'(out_index), 16'(idx));
      checkOutput({tag, " last"},  16'(out_last),  16'(last));
   endtask

   task automatic sendFrame(input int base);
      for (int k = 0; k < 16; k++) begin
         applyStimulus(1'b1, base + k, -(base + k));
      end
      in_valid = 1'b0;
      checkOutput($sformatf("frame %0d not started early", base), 16'(out_valid), 16'd0);
   endtask

   task automatic expectFrame(input int base, input int count);
      for (int n = 0; n < count; n++) begin
         tick();
         checkBeat($sformatf("frame %0d bin %0d", base, n), 1'b1,
                   base + order[n], -(base + order[n]), n, n == 15);
      end
   endtask

   initial begin
      rst      = 1'b1;
      enable   = 1'b1;
      in_valid = 1'b1;
      in_re    = 16'sd1234;
      in_im    = -16'sd5;

      // Reset held with valid input: everything stays at zero.
      for (int c = 0; c < 3; c++) begin
         tick();
         checkBeat($sformatf("reset cycle %0d", c), 1'b0, 0, 0, 0, 1'b0);
      end
      rst      = 1'b0;
      in_valid = 1'b0;
      tick();
      checkOutput("post-reset idle valid", 16'(out_valid), 16'd0);

      // Single frame, then outputs drop valid and hold data.
      sendFrame(0);
      expectFrame(0, 16);
      tick();
      checkOutput("single drained valid", 16'(out_valid), 16'd0);
      checkOutput("single drained last",  16'(out_last),  16'd0);
      checkOutput("single hold index",    16'(out_index), 16'd15);
      checkOutput("single hold re",       16'(out_re),    16'd15);
      checkOutput("single hold im",       16'(out_im),    16'(-15));

      // Three contiguous frames produce 48 contiguous outputs.
      for (int t = 0; t < 64; t++) begin
         if (t < 48) begin
            applyStimulus(1'b1, t, -t);
         end else begin
            applyStimulus(1'b0, 0, 0);
         end
         if (t == 15) begin
            checkOutput("b2b not started early", 16'(out_valid), 16'd0);
         end
         if (t >= 16) begin
            checkBeat($sformatf("b2b out %0d", t - 16), 1'b1,
                      ((t - 16) / 16) * 16 + order[(t - 16) % 16],
                      -(((t - 16) / 16) * 16 + order[(t - 16) % 16]),
                      (t - 16) % 16, ((t - 16) % 16) == 15);
         end
      end
      tick();
      checkOutput("b2b drained valid", 16'(out_valid), 16'd0);

      // Input every other cycle: same result, start one edge after last input.
      for (int k = 0; k < 16; k++) begin
         applyStimulus(1'b1, k, -k);
         if (k < 15) begin
            applyStimulus(1'b0, 0, 0);
         end
      end
      in_valid = 1'b0;
      checkOutput("gaps not started early", 16'(out_valid), 16'd0);
      expectFrame(0, 16);
      tick();
      checkOutput("gaps drained valid", 16'(out_valid), 16'd0);

      // Signed extremes on even arrivals land in bins 0..7.
      for (int k = 0; k < 16; k++) begin
         applyStimulus(1'b1, (k % 2 == 0) ? -32768 : 0, (k % 2 == 0) ? 32767 : 0);
      end
      in_valid = 1'b0;
      for (int n = 0; n < 16; n++) begin
         tick();
         checkBeat($sformatf("extreme bin %0d", n), 1'b1,
                   (n < 8) ? -32768 : 0, (n < 8) ? 32767 : 0, n, n == 15);
      end
      tick();

      // Reset after 9 inputs drops the partial frame.
      for (int k = 0; k < 9; k++) begin
         applyStimulus(1'b1, 100 + k, -(100 + k));
      end
      rst = 1'b1;
      applyStimulus(1'b1, 7, 7);
      checkBeat("rst mid-write", 1'b0, 0, 0, 0, 1'b0);
      rst = 1'b0;
      applyStimulus(1'b0, 0, 0);
      sendFrame(32);
      expectFrame(32, 16);
      tick();

      // Enable low after 9 inputs; valid input is ignored while disabled.
      for (int k = 0; k < 9; k++) begin
         applyStimulus(1'b1, 200 + k, -(200 + k));
      end
      enable = 1'b0;
      applyStimulus(1'b1, 9, 9);
      checkBeat("enable off mid-write", 1'b0, 0, 0, 0, 1'b0);
      applyStimulus(1'b1, 9, 9);
      enable = 1'b1;
      applyStimulus(1'b0, 0, 0);
      sendFrame(48);
      expectFrame(48, 6);

      // Enable low during readout at bin 5 abandons the frame.
      enable = 1'b0;
      applyStimulus(1'b1, 3, 3);
      checkBeat("enable off mid-read", 1'b0, 0, 0, 0, 1'b0);
      enable = 1'b1;
      applyStimulus(1'b0, 0, 0);
      tick();
      checkOutput("no stale frame after clear", 16'(out_valid), 16'd0);
      sendFrame(64);
      expectFrame(64, 16);
      tick();
      checkOutput("final drained valid", 16'(out_valid), 16'd0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
